// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared definitions for the data memory controller:
//                access-size encodings and the controller FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_fmt
//  Description : Combinational byte-lane formatter. Builds the store lane
//                mask and lane-replicated store data, and extracts/extends
//                sub-word load data from a full memory word.
//  Ports       : i_size     - access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//                i_unsigned - zero-extend sub-word loads when 1
//                i_lane     - byte address bits [1:0]
//                i_wdata    - right-aligned store data
//                i_rword    - memory word read for a load
//                o_wmask    - byte lanes to write
//                o_wdata    - store data placed on every candidate lane
//                o_rdata    - extracted and extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
    import data_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_wmask = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = 32'h0;
        case (i_size)
            SZ_BYTE: begin
                // Replicating the byte lets the mask alone select the lane
                o_wmask = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_wmask = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_wmask = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_wmask = 4'b0000;
                o_wdata = i_wdata;
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Single-port word memory with a request/response controller.
//                Byte/half/word loads and stores, alignment and range fault
//                detection, programmable extra access latency.
//  Ports       : clk, rst            - clock, async active-high reset
//                req_valid/req_ready - request handshake
//                req_write, req_size, req_unsigned, req_addr, req_wdata
//                                    - request attributes
//                rsp_valid           - one-cycle response pulse
//                rsp_rdata/rsp_fault - response data / fault flag
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] C_LAST = 3'(WAIT_CYCLES - 1);

    state_t      r_state, w_next_state;
    logic [2:0]  r_wcnt, w_next_wcnt;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_fault;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_cur_write;
    logic [1:0]  w_cur_size;
    logic        w_cur_unsigned;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic        w_fault;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rword;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata_lanes;
    logic [31:0] w_fmt_rdata;

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;

    // With zero wait cycles the RESP-entry edge is the acceptance edge, so the
    // live request is used there; otherwise the captured copy is used.
    assign w_cur_write    = (r_state == IDLE) ? req_write    : r_write;
    assign w_cur_size     = (r_state == IDLE) ? req_size     : r_size;
    assign w_cur_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;
    assign w_cur_addr     = (r_state == IDLE) ? req_addr     : r_addr;
    assign w_cur_wdata    = (r_state == IDLE) ? req_wdata    : r_wdata;

    always_comb begin
        w_fault = 1'b0;
        case (w_cur_size)
            SZ_HALF: w_fault = w_cur_addr[0];
            SZ_WORD: w_fault = |w_cur_addr[1:0];
            SZ_ILL:  w_fault = 1'b1;
            default: w_fault = 1'b0;
        endcase
        if ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            w_fault = 1'b1;
        end
    end

    assign w_idx   = w_cur_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];

    mem_lane_fmt u_fmt (
        .i_size     (w_cur_size),
        .i_unsigned (w_cur_unsigned),
        .i_lane     (w_cur_addr[1:0]),
        .i_wdata    (w_cur_wdata),
        .i_rword    (w_rword),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata_lanes),
        .o_rdata    (w_fmt_rdata)
    );

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_next_wcnt  = r_wcnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_wcnt = 3'd0;
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == C_LAST) begin
                    w_next_state = RESP;
                end else begin
                    w_next_wcnt = r_wcnt + 3'd1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
                w_next_wcnt  = 3'd0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_wcnt  = 3'd0;
            end
        endcase
    end

    assign w_enter_resp = (w_next_state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wcnt      <= 3'd0;
            r_write     <= 1'b0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_wcnt  <= w_next_wcnt;
            if (w_accept) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            // Response registers are loaded only on RESP entry and cleared
            // on every other edge, so they read zero outside RESP.
            r_rsp_rdata <= (w_enter_resp && !w_fault && !w_cur_write) ? w_fmt_rdata : 32'h0;
            r_rsp_fault <= w_enter_resp && w_fault;
        end
    end

    // Memory contents are not reset. The rst term blocks a write while reset
    // is held, since the next-state logic still sees the live request then.
    always_ff @(posedge clk) begin
        if (w_enter_resp && !rst && !w_fault && w_cur_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Directed self-checking bench for data_mem_ctrl. One instance
//                with no extra latency, one with three wait cycles; both share
//                the request attribute bus and have private valid/reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        valid0, valid3;
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;

    logic        ready0, rv0, flt0;
    logic [31:0] rd0;
    logic        ready3, rv3, flt3;
    logic [31:0] rd3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(valid0), .req_ready(ready0),
        .req_write(wr), .req_size(sz), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(flt0)
    );

    data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(ready3),
        .req_write(wr), .req_size(sz), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(flt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to instance sel (0: no wait, 1: three wait cycles),
    // then check latency, response data/fault, and the following idle cycle.
    task automatic req(input bit sel, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_flt, input string tag);
        int lat;
        @(negedge clk);
        wr = w; sz = s; uns = u; addr = a; wdata = d;
        if (sel) valid3 = 1'b1; else valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0; valid3 = 1'b0;
        // Attribute changes after acceptance must be ignored
        wr = ~w; sz = ~s; uns = ~u; addr = ~a; wdata = ~d;
        lat = 1;
        while (!(sel ? rv3 : rv0) && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), sel ? 32'd4 : 32'd1);
        chk({tag, "/rdata"}, sel ? rd3 : rd0, exp_rd);
        chk({tag, "/fault"}, 32'(sel ? flt3 : flt0), 32'(exp_flt));
        @(posedge clk);
        #1;
        chk({tag, "/idle"}, sel ? {rv3, flt3, rd3[29:0]} : {rv0, flt0, rd0[29:0]}, 32'h0);
    endtask

    initial begin
        logic [6:1]  rdy_seq, rv_seq;
        logic [31:0] rd_at4;
        int          seen;

        rst0 = 1'b1; rst3 = 1'b1; valid0 = 1'b0; valid3 = 1'b0;
        wr = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        @(posedge clk);
        #1;
        chk("reset0", {ready0, rv0, flt0, |rd0}, 4'b1000);
        chk("reset3", {ready3, rv3, flt3, |rd3}, 4'b1000);

        // No-wait instance: word store/load round trip
        req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, "sw_deadbeef");
        req(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, "lw_deadbeef");

        // Byte store into an existing word, signed/unsigned byte loads
        req(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0, "sw_11223344");
        req(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0,        0, "sb_80");
        req(0, 0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, "lb_13");
        req(0, 0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, "lbu_13");
        req(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h80223344, 0, "lw_after_sb");
        req(0, 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF8022, 0, "lh_12");
        req(0, 0, 2'b01, 1, 32'h10, 32'h0,        32'h00003344, 0, "lhu_10");
        req(0, 0, 2'b00, 0, 32'h12, 32'h0,        32'h00000022, 0, "lb_12");

        // Fault cases: misaligned half/word, illegal size, out of range
        req(0, 0, 2'b01, 0, 32'h11,   32'h0,        32'h0, 1, "lh_misalign");
        req(0, 1, 2'b10, 0, 32'h12,   32'hAAAAAAAA, 32'h0, 1, "sw_misalign");
        req(0, 1, 2'b11, 0, 32'h10,   32'hAAAAAAAA, 32'h0, 1, "size_illegal");
        req(0, 1, 2'b10, 0, 32'h1000, 32'hAAAAAAAA, 32'h0, 1, "sw_range");
        req(0, 0, 2'b10, 0, 32'h1000, 32'h0,        32'h0, 1, "lw_range");
        req(0, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80223344, 0, "lw_unchanged");
        // Index aliasing check: word 0 must not have been hit by the range store
        req(0, 0, 2'b10, 0, 32'h0,    32'h0,        32'h0, 0, "lw_word0");

        // Half store into upper lanes
        req(0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF, 32'h0,        0, "sh_beef");
        req(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hBEEF3344, 0, "lw_after_sh");

        // Three-wait instance: known contents at 0x20, then held-valid timing
        req(1, 1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, "w3_sw_zero");

        @(negedge clk);
        wr = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h0;
        valid3 = 1'b1;
        chk("w3_ready_before", 32'(ready3), 32'd1);
        @(posedge clk);
        rd_at4 = 32'hFFFFFFFF;
        for (int c = 1; c <= 6; c++) begin
            #1;
            rdy_seq[c] = ready3;
            rv_seq[c]  = rv3;
            if (c == 4) rd_at4 = rd3;
            if (c == 6) valid3 = 1'b0;
            @(posedge clk);
        end
        chk("w3_ready_seq", 32'(rdy_seq), 32'(6'b010000));
        chk("w3_rvalid_seq", 32'(rv_seq), 32'(6'b001000));
        chk("w3_rdata", rd_at4, 32'h0);
        // Drain the back-to-back request accepted in cycle 5
        seen = 0;
        #1;
        while (!rv3 && seen < 10) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("w3_second_resp", 32'(rv3), 32'd1);
        @(posedge clk);

        // Reset during WAIT discards the store and its response
        @(negedge clk);
        wr = 1'b1; sz = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h12345678;
        valid3 = 1'b1;
        @(posedge clk);
        #1;
        valid3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (rv3) seen++;
        end
        chk("w3_rst_no_rsp", 32'(seen), 32'd0);
        chk("w3_rst_ready", 32'(ready3), 32'd1);
        req(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, "w3_lw_after_rst");

        // Wait-instance store/load to confirm normal operation resumes
        req(1, 1, 2'b00, 0, 32'h21, 32'h000000A5, 32'h0,        0, "w3_sb_a5");
        req(1, 0, 2'b00, 0, 32'h21, 32'h0,        32'hFFFFFFA5, 0, "w3_lb_a5");
        req(1, 0, 2'b10, 0, 32'h20, 32'h0,        32'h0000A500, 0, "w3_lw_a500");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words, power of two, 4..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra access latency cycles, 0..7.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  single-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and faults.
REQ-014 SHALL have port rsp_fault  output  1  access rejected; valid with rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-017 SHALL register req_write, req_size, req_unsigned, req_addr, req_wdata on acceptance; later input changes have no effect.
REQ-018 SHALL transition IDLE->WAIT on acceptance when WAIT_CYCLES>0, else IDLE->RESP.
REQ-019 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP; RESP->IDLE unconditionally after one cycle.
REQ-020 SHALL assert rsp_valid exactly during RESP, giving accept-to-response latency of WAIT_CYCLES+1 cycles and one request every WAIT_CYCLES+2 cycles at most.
REQ-021 SHALL flag a fault when req_size=11, half access has addr[0]=1, word access has addr[1:0]!=00, or addr[31:2] >= DEPTH_WORDS.
REQ-022 SHALL, on fault, perform no memory write and return rsp_rdata=0, rsp_fault=1.
REQ-023 SHALL commit a non-faulting store on the clock edge entering RESP, writing only the addressed byte lanes: byte lane addr[1:0], half lanes addr[1]*2..+1, word all four lanes.
REQ-024 SHALL return, for a non-faulting load, the memory word read in the cycle entering RESP, lane-extracted by addr[1:0] and extended per req_unsigned/req_size; word loads ignore req_unsigned.
REQ-025 SHALL guarantee a load issued after a completed store to the same word returns the stored data (no stale read).
REQ-026 SHALL keep rsp_rdata and rsp_fault at 0 outside RESP.
REQ-027 SHALL index memory by addr[log2(DEPTH_WORDS)+1:2]; upper address bits participate only in the range check.

Reset
REQ-028 SHALL on rst force state IDLE, wait counter 0, req_ready=1 after reset release, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
REQ-029 SHALL, when rst asserts mid-operation (WAIT or before the RESP edge), discard the request with no memory write and no response.
REQ-030 SHALL not reset memory contents; simulation initial contents are all zero.

Structure
REQ-031 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type in shared package data_mem_pkg.
REQ-032 SHALL isolate store lane mask/shift and load extract/extend logic in combinational sub-module mem_lane_fmt.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=0, SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 1 cycle after each accept, rdata 0xDEADBEEF, fault 0.
REQ-034 SHALL cover: SB 0x80 @0x13 over word 0x11223344, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80223344.
REQ-035 SHALL cover: LH @0x11, SW @0x12, size=11, addr=DEPTH_WORDS*4 -> fault=1, rdata=0, memory unchanged (verified by LW).
REQ-036 SHALL cover: WAIT_CYCLES=3, LW with req_valid held high -> req_ready low 4 cycles, rsp_valid 4 cycles after accept, next accept in the cycle after RESP.
REQ-037 SHALL cover: WAIT_CYCLES=3, SW 0x12345678 @0x20, rst asserted in WAIT -> no rsp_valid; subsequent LW @0x20 returns prior value 0.
